// File: rtl/ro_puf_pkg.sv
// Shared types and helpers for the RO-PUF pair counter.
package ro_puf_pkg;

  // Default width of the per-oscillator edge counters.
  localparam int CNT_W_DEF = 16;

  // Measurement sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Ceiling log2 for sizing counters from elaboration-time constants.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Synchronises one free-running oscillator into clk and flags sampled rising edges.
module ro_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  // Shift the raw input through the synchroniser; history holds the previous synced level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and history flops, cleared on reset so no phantom edge survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  // Both operands are flops, so the pulse is glitch-free.
  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/ro_pair_counter.sv
// RO-PUF measurement stage: enables two ring oscillators, counts their sampled
// rising edges over a fixed window and compares the counts into one response bit.
// Optional margin flag (output 'reliable') is built when RO_MARGIN_CHECK_EN is defined.
module ro_pair_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WINDOW      = 1024,
  parameter int SETTLE      = 4,
  parameter int SYNC_STAGES = 2
`ifdef RO_MARGIN_CHECK_EN
  ,
  parameter int MARGIN      = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic             response,
  output logic             tie,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
`ifdef RO_MARGIN_CHECK_EN
  ,
  output logic             reliable
`endif
);

  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
  logic             ro_en_q, ro_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             response_q, response_d;
  logic             tie_q, tie_d;
  logic [CNT_W-1:0] count_a_q, count_a_d;
  logic [CNT_W-1:0] count_b_q, count_b_d;
  logic             edge_a_s, edge_b_s;

  ro_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (ro_a),
    .edge_pulse (edge_a_s)
  );

  ro_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (ro_b),
    .edge_pulse (edge_b_s)
  );

`ifdef RO_MARGIN_CHECK_EN
  localparam logic [CNT_W:0] MARGIN_V = (CNT_W+1)'(MARGIN);
  logic [CNT_W:0] diff_s;
  logic           reliable_q, reliable_d;

  // Absolute count difference, one bit wider than the counters so it cannot overflow.
  always_comb begin
    if (cnt_a_q >= cnt_b_q) begin
      diff_s = {1'b0, cnt_a_q} - {1'b0, cnt_b_q};
    end else begin
      diff_s = {1'b0, cnt_b_q} - {1'b0, cnt_a_q};
    end
  end

  assign reliable = reliable_q;
`endif

  // Sequencer next-state, phase timer, saturating counters and result capture.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    ro_en_d    = ro_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    response_d = response_q;
    tie_d      = tie_q;
    count_a_d  = count_a_q;
    count_b_d  = count_b_q;
`ifdef RO_MARGIN_CHECK_EN
    reliable_d = reliable_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SETTLE;
          tmr_d      = '0;
          cnt_a_d    = '0;
          cnt_b_d    = '0;
          response_d = 1'b0;
          tie_d      = 1'b0;
          count_a_d  = '0;
          count_b_d  = '0;
`ifdef RO_MARGIN_CHECK_EN
          reliable_d = 1'b0;
`endif
          ro_en_d    = 1'b1;
          busy_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        // Edges seen here come from stale synchroniser contents and are dropped.
        if (tmr_q == SETTLE_LAST) begin
          state_d = ST_MEASURE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_MEASURE: begin
        if (edge_a_s && (cnt_a_q != CNT_MAX)) begin
          cnt_a_d = cnt_a_q + 1'b1;
        end else begin
          cnt_a_d = cnt_a_q;
        end
        if (edge_b_s && (cnt_b_q != CNT_MAX)) begin
          cnt_b_d = cnt_b_q + 1'b1;
        end else begin
          cnt_b_d = cnt_b_q;
        end
        if (tmr_q == WINDOW_LAST) begin
          state_d = ST_COMPARE;
          tmr_d   = '0;
          ro_en_d = 1'b0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_COMPARE: begin
        response_d = (cnt_a_q > cnt_b_q);
        tie_d      = (cnt_a_q == cnt_b_q);
        count_a_d  = cnt_a_q;
        count_b_d  = cnt_b_q;
`ifdef RO_MARGIN_CHECK_EN
        reliable_d = (diff_s >= MARGIN_V);
`endif
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ro_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, timer, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      ro_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      response_q <= 1'b0;
      tie_q      <= 1'b0;
      count_a_q  <= '0;
      count_b_q  <= '0;
`ifdef RO_MARGIN_CHECK_EN
      reliable_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      ro_en_q    <= ro_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      response_q <= response_d;
      tie_q      <= tie_d;
      count_a_q  <= count_a_d;
      count_b_q  <= count_b_d;
`ifdef RO_MARGIN_CHECK_EN
      reliable_q <= reliable_d;
`endif
    end
  end

  assign ro_en    = ro_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign response = response_q;
  assign tie      = tie_q;
  assign count_a  = count_a_q;
  assign count_b  = count_b_q;

endmodule
